// File: rtl/vga_pkg.sv
// Shared types and helpers for the parametrised VGA timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRID   = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_STREAM = 2'd3
  } mode_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  typedef struct packed {
    logic [31:0] htotal;
    logic [31:0] vtotal;
  } vga_timing_t;

  function automatic vga_timing_t vga_timing(int hdisp, int hfp, int hpulse, int hbp,
                                             int vdisp, int vfp, int vpulse, int vbp);
    vga_timing_t t;
    t.htotal = 32'(hdisp + hfp + hpulse + hbp);
    t.vtotal = 32'(vdisp + vfp + vpulse + vbp);
    return t;
  endfunction

  function automatic int cwidth(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_if.sv
// Parallel video bus towards the HDMI/VGA PHY; BLANK high marks an active pixel.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_pattern.sv
// Combinational pixel source: maps mode and the coming pixel coordinate to its colour.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int          HDISP         = 800,
  parameter int          GRID_LOG2     = 4,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF0000,
  parameter int          XW            = 10,
  parameter int          YW            = 9
) (
  input  mode_t          mode,
  input  logic [XW-1:0]  x,
  input  logic [YW-1:0]  y,
  input  logic [23:0]    solid_rgb,
  input  logic [23:0]    pix_data,
  input  logic           pix_valid,
  output logic [23:0]    rgb
);

  localparam int BAR_W = (HDISP >= 8) ? HDISP / 8 : 1;
  localparam int GMASK = (1 << GRID_LOG2) - 1;

  logic       on_grid;
  logic [2:0] bar_idx;
  int         bar;

  always_comb begin
    on_grid = ((int'(x) & GMASK) == 0) || ((int'(y) & GMASK) == 0);
    bar     = int'(x) / BAR_W;
    // Remainder columns past the eighth bar stay in the last bar.
    bar_idx = (bar > 7) ? 3'd7 : bar[2:0];
    rgb     = '0;
    case (mode)
      MODE_GRID:   rgb = on_grid ? 24'hFFFFFF : 24'h000000;
      MODE_BARS:   rgb = BAR_RGB[bar_idx];
      MODE_SOLID:  rgb = solid_rgb;
      MODE_STREAM: rgb = pix_valid ? pix_data : UNDERFLOW_RGB;
      default:     rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/HDMI timing generator with pattern and stream sources.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          HDISP         = 800,
  parameter int          VDISP         = 480,
  parameter int          HFP           = 40,
  parameter int          HPULSE        = 48,
  parameter int          HBP           = 40,
  parameter int          VFP           = 13,
  parameter int          VPULSE        = 3,
  parameter int          VBP           = 29,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int          GRID_LOG2     = 4,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF0000,
  localparam int         XW            = cwidth(HDISP),
  localparam int         YW            = cwidth(VDISP)
) (
  input  logic           pixel_clk,
  input  logic           pixel_rst_n,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic [23:0]    solid_rgb,
  input  logic           pix_valid,
  input  logic [23:0]    pix_data,
  output logic           pix_ready,
  output logic           frame_start,
  output logic           line_start,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           underflow,
  input  logic           underflow_clr,
  video_if.master        video_ifm
);

  localparam vga_timing_t TIM    = vga_timing(HDISP, HFP, HPULSE, HBP, VDISP, VFP, VPULSE, VBP);
  localparam int          HTOTAL = int'(TIM.htotal);
  localparam int          VTOTAL = int'(TIM.vtotal);
  localparam int          HW     = cwidth(HTOTAL);
  localparam int          VW     = cwidth(VTOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC = HW'(HFP);
  localparam logic [HW-1:0] H_BP   = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC = VW'(VFP);
  localparam logic [VW-1:0] V_BP   = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT  = VW'(VFP + VPULSE + VBP);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  mode_t         mode_q;
  logic          reload;
  logic          h_wrap, frame_last, active, hs_nxt, vs_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic [23:0]   pat_rgb;
  logic          hs_q, vs_q, blank_q;
  logic [23:0]   rgb_q;

  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_last = h_wrap && (v_cnt == V_LAST);
  assign active     = (h_cnt >= H_ACT) && (v_cnt >= V_ACT);
  assign x_nxt      = XW'(h_cnt - H_ACT);
  assign y_nxt      = YW'(v_cnt - V_ACT);
  assign hs_nxt     = ((h_cnt >= H_SYNC) && (h_cnt < H_BP)) ? HS_POL : ~HS_POL;
  assign vs_nxt     = ((v_cnt >= V_SYNC) && (v_cnt < V_BP)) ? VS_POL : ~VS_POL;

  // Handshake and markers decode the counters directly, one cycle ahead of RGB.
  assign pix_ready   = en && active && (mode_q == MODE_STREAM);
  assign line_start  = en && active && (h_cnt == H_ACT);
  assign frame_start = line_start && (v_cnt == V_ACT);

  vga_pattern #(
    .HDISP         (HDISP),
    .GRID_LOG2     (GRID_LOG2),
    .UNDERFLOW_RGB (UNDERFLOW_RGB),
    .XW            (XW),
    .YW            (YW)
  ) u_pattern (
    .mode      (mode_q),
    .x         (x_nxt),
    .y         (y_nxt),
    .solid_rgb (solid_rgb),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .rgb       (pat_rgb)
  );

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      mode_q    <= MODE_GRID;
      reload    <= 1'b1;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
      x         <= '0;
      y         <= '0;
      underflow <= 1'b0;
    end else begin
      if (pix_ready && !pix_valid) underflow <= 1'b1;
      else if (underflow_clr)      underflow <= 1'b0;

      if (!en) begin
        h_cnt   <= '0;
        v_cnt   <= '0;
        mode_q  <= mode_t'(mode);
        reload  <= 1'b1;
        hs_q    <= ~HS_POL;
        vs_q    <= ~VS_POL;
        blank_q <= 1'b0;
        rgb_q   <= '0;
        x       <= '0;
        y       <= '0;
      end else begin
        reload <= 1'b0;
        // Mode only changes at frame boundaries so a frame is never torn.
        if (reload || frame_last) mode_q <= mode_t'(mode);
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        hs_q    <= hs_nxt;
        vs_q    <= vs_nxt;
        blank_q <= active;
        rgb_q   <= active ? pat_rgb : '0;
        x       <= active ? x_nxt : '0;
        y       <= active ? y_nxt : '0;
      end
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;

endmodule
